// File: rtl/proc_pkg.sv
// Shared constants and helpers for the processor datapath register bank.
package proc_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Address width for a bank of the given depth; never narrower than one bit.
  function automatic int addr_width(input int depth);
    if (depth <= 2) return 1;
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One WIDTH-wide storage cell: load on en, synchronous clear, async active-low reset.
module regfile_entry #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next value: clear wins over a load.
  always_comb begin
    data_d = data_q;
    if (clear)   data_d = '0;
    else if (en) data_d = d;
  end

  // Storage flop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) data_q <= '0;
    else         data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register bank: one synchronous write port, two combinational
// read ports with optional write bypass, optional hardwired-zero entry 0.
module register_file
  import proc_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int ADDR_W   = addr_width(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [DEPTH-1:0]  valid_mask
);

  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] zero_mask;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic             wr_live;
  logic             byp_a;
  logic             byp_b;

  // A write only lands when not cleared; entry 0 never accepts one in zero mode.
  assign wr_live = we && !clear;

  // One-hot write decode.
  always_comb begin
    wr_sel = '0;
    if (wr_live) wr_sel[waddr] = 1'b1;
    if (ZERO_REG != 0) wr_sel[0] = 1'b0;
  end

  // Storage cells; entry 0 is a constant when it is the zero register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign entry_q[i] = '0;
    end else begin : g_cell
      regfile_entry #(.WIDTH(WIDTH)) u_entry (
        .clock  (clock),
        .resetn (resetn),
        .clear  (clear),
        .en     (wr_sel[i]),
        .d      (wdata),
        .q      (entry_q[i])
      );
    end
  end

  // Valid bits: set by a landed write, dropped by clear.
  always_comb begin
    valid_d = valid_q | wr_sel;
    if (clear) valid_d = '0;
  end

  // Valid flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Entry 0 always reports valid in zero mode, even while in reset.
  always_comb begin
    zero_mask    = '0;
    zero_mask[0] = (ZERO_REG != 0);
  end

  assign valid_mask = valid_q | zero_mask;

  // Bypass compare; held off during reset so reads stay zero, and never for the zero register.
  always_comb begin
    byp_a = (BYPASS != 0) && resetn && wr_live && (raddr_a == waddr);
    byp_b = (BYPASS != 0) && resetn && wr_live && (raddr_b == waddr);
    if (ZERO_REG != 0 && raddr_a == '0) byp_a = 1'b0;
    if (ZERO_REG != 0 && raddr_b == '0) byp_b = 1'b0;
  end

  // Read muxes.
  always_comb begin
    rdata_a = byp_a ? wdata : entry_q[raddr_a];
    rdata_b = byp_b ? wdata : entry_q[raddr_b];
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a default instance (bypass on) and a zero-register
// instance (bypass off) share stimulus and are checked against array models.
module tb_register_file;

  logic        clock = 1'b0;
  logic        resetn;
  logic        clear;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic [7:0]  valid0, valid1;

  int checks   = 0;
  int failures = 0;

  register_file dut (
    .clock(clock), .resetn(resetn), .clear(clear), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b),
    .rdata_b(rdata_b0), .valid_mask(valid0)
  );

  register_file #(.BYPASS(0), .ZERO_REG(1)) dut_z (
    .clock(clock), .resetn(resetn), .clear(clear), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b),
    .rdata_b(rdata_b1), .valid_mask(valid1)
  );

  always #5 clock = ~clock;

  // Reference state: plain arrays of what each bank should hold.
  logic [15:0] m0 [8];
  logic [15:0] m1 [8];
  logic [7:0]  v0, v1;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd0(input logic [2:0] ra);
    if (!resetn) return 16'h0;
    if (we && !clear && ra == waddr) return wdata;
    return m0[ra];
  endfunction

  function automatic logic [15:0] exp_rd1(input logic [2:0] ra);
    if (!resetn || ra == 3'd0) return 16'h0;
    return m1[ra];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 8; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    v0 = '0;
    v1 = '0;
  endtask

  task automatic check_model(input string tag);
    if (!resetn) model_zero();
    cmp({tag, " a0"}, rdata_a0, exp_rd0(raddr_a));
    cmp({tag, " b0"}, rdata_b0, exp_rd0(raddr_b));
    cmp({tag, " v0"}, {8'h0, valid0}, {8'h0, v0});
    cmp({tag, " a1"}, rdata_a1, exp_rd1(raddr_a));
    cmp({tag, " b1"}, rdata_b1, exp_rd1(raddr_b));
    cmp({tag, " v1"}, {8'h0, valid1}, {8'h0, v1 | 8'h01});
  endtask

  task automatic update_model();
    if (!resetn) return;
    if (clear) begin
      model_zero();
    end else if (we) begin
      m0[waddr] = wdata;
      v0[waddr] = 1'b1;
      if (waddr != 3'd0) begin
        m1[waddr] = wdata;
        v1[waddr] = 1'b1;
      end
    end
  endtask

  // Inputs are driven just after an edge; check late in the cycle, then take the edge.
  task automatic finish_cycle(input string tag);
    check_model(tag);
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic step(input string tag);
    #3;
    finish_cycle(tag);
  endtask

  task automatic drive(input logic c, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
    clear = c; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
  endtask

  typedef struct {
    logic        clr;
    logic        w;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [7:0]  exp_v;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Expected values for the default (bypass) instance, sampled before each edge.
    vecs[0] = '{1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 8'h08};
    vecs[2] = '{1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234, 8'h08};
    vecs[3] = '{1'b0, 1'b1, 3'd1, 16'h00AA, 3'd5, 3'd1, 16'h1234, 16'h00AA, 8'h28};
    vecs[4] = '{1'b0, 1'b1, 3'd2, 16'h00AA, 3'd1, 3'd2, 16'h00AA, 16'h00AA, 8'h2A};
    vecs[5] = '{1'b1, 1'b1, 3'd1, 16'h5555, 3'd1, 3'd2, 16'h00AA, 16'h00AA, 8'h2E};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 16'h0000, 16'h0000, 8'h00};
    vecs[7] = '{1'b0, 1'b1, 3'd7, 16'h0001, 3'd3, 3'd6, 16'h0000, 16'h0000, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 3'd7, 16'h0002, 3'd3, 3'd7, 16'h0000, 16'h0002, 8'h80};
    vecs[9] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, 16'h0002, 16'h0002, 8'h80};

    resetn = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    model_zero();
    #3;
    check_model("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      #3;
      cmp($sformatf("vec%0d a", i), rdata_a0, vecs[i].exp_a);
      cmp($sformatf("vec%0d b", i), rdata_b0, vecs[i].exp_b);
      cmp($sformatf("vec%0d v", i), {8'h0, valid0}, {8'h0, vecs[i].exp_v});
      finish_cycle($sformatf("vec%0d", i));
    end

    // Zero register: writes to address 0 never show on the zero-mode instance.
    drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    #3;
    cmp("zero same-cycle", rdata_a1, 16'h0000);
    cmp("zero valid0", {15'h0, valid1[0]}, 16'h0001);
    finish_cycle("zero_wr");
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1);
    #3;
    cmp("zero after edge", rdata_a1, 16'h0000);
    cmp("default addr0 stored", rdata_a0, 16'hFFFF);
    finish_cycle("zero_rd");

    // Fill every entry, then drop reset between edges.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 3'(i), 16'($urandom) | 16'h0100, 3'(i), 3'((i + 1) % 8));
      step("fill");
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd6, 3'd7);
    #2;
    resetn = 1'b0;
    #1;
    cmp("async rst a", rdata_a0, 16'h0000);
    cmp("async rst b", rdata_b1, 16'h0000);
    cmp("async rst v", {8'h0, valid0}, 16'h0000);
    check_model("async_rst");
    #1;
    drive(1'b0, 1'b1, 3'd4, 16'hABCD, 3'd2, 3'd3);
    step("wr_in_rst");
    resetn = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd4);
    #3;
    cmp("write in reset lost", rdata_a0, 16'h0000);
    cmp("valid after reset", {8'h0, valid0}, 16'h0000);
    finish_cycle("post_rst");

    // Randomised traffic against the models.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
